card_dealer: RTL

- Card source for the blackjack game; drives the 4-bit card value consumed by the game FSM.
- Holds one 52-card deck in a register array and shuffles it in hardware (Fisher-Yates, LFSR-driven).
- Serves one card per request with a valid pulse; reports cards remaining and deck-empty status.

---
 rtl/blackjack_pkg.sv | 28 ++
 rtl/deck_lfsr.sv | 35 +++
 rtl/card_dealer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/blackjack_pkg.sv
// Shared constants and types for the blackjack card source: deck geometry,
// card values, dealer state encoding and the deck LFSR polynomial.
package blackjack_pkg;

    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;

    localparam logic [3:0]  CARD_ACE  = 4'd1;
    localparam logic [3:0]  CARD_TEN  = 4'd10;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        INIT    = 2'd1,
        SHUFFLE = 2'd2,
        READY   = 2'd3
    } dealer_state_e;

    // Rank 0 is the ace; ranks 9..12 (ten, J, Q, K) all score as ten.
    function automatic logic [3:0] rank_value(input logic [3:0] rank);
        return (rank < 4'd9) ? rank + CARD_ACE : CARD_TEN;
    endfunction

    function automatic logic [5:0] pick_index(input logic [5:0] rnd, input logic [5:0] i);
        return 6'(({6'd0, rnd} * ({6'd0, i} + 12'd1)) >> 6);
    endfunction

endpackage

// File: rtl/deck_lfsr.sv
// Free-running 16-bit Galois LFSR with seed load; a zero seed is replaced by
// SEED so the register can never lock up.
module deck_lfsr
    import blackjack_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load_i,
    input  logic [15:0] seed_i,
    output logic [5:0]  rnd_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
        if (seed_load_i) begin
            lfsr_d = (seed_i == 16'd0) ? SEED : seed_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd_o = lfsr_q[5:0];

endmodule

// File: rtl/card_dealer.sv
// Blackjack card source: builds a 52-card deck, Fisher-Yates shuffles it in
// place one swap per cycle, then serves one card per request.
module card_dealer
    import blackjack_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          RESHUFFLE_AT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        shuffle_start,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    input  logic        card_req,
    output logic        card_valid,
    output logic [3:0]  card_value,
    output logic [5:0]  cards_left,
    output logic        deck_empty,
    output logic        busy,
    output logic        shuffle_done,
    output logic        low_deck
);

    localparam logic [5:0] LAST_IDX  = 6'(DECK_SIZE - 1);
    localparam logic [5:0] FULL_DECK = 6'(DECK_SIZE);
    localparam logic [3:0] LAST_RANK = 4'(RANKS - 1);

    dealer_state_e state_q;
    logic [3:0]    deck_q [DECK_SIZE];
    logic [5:0]    idx_q;
    logic [3:0]    rank_q;
    logic [5:0]    ptr_q;
    logic [5:0]    left_q;
    logic          valid_q;
    logic [3:0]    value_q;
    logic          busy_q;
    logic          done_q;
    logic [5:0]    rnd;
    logic [5:0]    swap_j;

    deck_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk         (clk),
        .rst         (rst),
        .seed_load_i (seed_load),
        .seed_i      (seed_in),
        .rnd_o       (rnd)
    );

    assign swap_j = pick_index(rnd, idx_q);

    // idx_q walks up through the deck while filling, then down as the swap index.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            deck_q[idx_q] <= rank_value(rank_q);
        end else if (state_q == SHUFFLE) begin
            deck_q[idx_q]  <= deck_q[swap_j];
            deck_q[swap_j] <= deck_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            rank_q  <= '0;
            ptr_q   <= '0;
            left_q  <= '0;
            valid_q <= 1'b0;
            value_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                EMPTY: begin
                    if (shuffle_start) begin
                        state_q <= INIT;
                        idx_q   <= '0;
                        rank_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                INIT: begin
                    rank_q <= (rank_q == LAST_RANK) ? 4'd0 : rank_q + 4'd1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= SHUFFLE;
                    end else begin
                        idx_q <= idx_q + 6'd1;
                    end
                end
                SHUFFLE: begin
                    if (idx_q == 6'd1) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        left_q  <= FULL_DECK;
                        ptr_q   <= '0;
                    end else begin
                        idx_q <= idx_q - 6'd1;
                    end
                end
                READY: begin
                    // A reshuffle request beats a simultaneous deal.
                    if (shuffle_start) begin
                        state_q <= INIT;
                        idx_q   <= '0;
                        rank_q  <= '0;
                        left_q  <= '0;
                        busy_q  <= 1'b1;
                    end else if (card_req && left_q != 6'd0) begin
                        valid_q <= 1'b1;
                        value_q <= deck_q[ptr_q];
                        ptr_q   <= ptr_q + 6'd1;
                        left_q  <= left_q - 6'd1;
                        if (left_q == 6'd1) begin
                            state_q <= EMPTY;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign card_valid   = valid_q;
    assign card_value   = value_q;
    assign cards_left   = left_q;
    assign busy         = busy_q;
    assign shuffle_done = done_q;
    assign deck_empty   = (left_q == 6'd0) && !busy_q;
    assign low_deck     = (RESHUFFLE_AT != 0) && (int'(left_q) <= RESHUFFLE_AT);

endmodule
